// File: rtl/apb_slave_regfile.sv
// APB completer backed by a word-addressed register file.
// Supports programmable wait states and reports bad accesses on pslverr.
module apb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 33,
    parameter int DATA_W      = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [1:0]        fsm_state
);

    // Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
    // access cycles (psel=1, penable=1); it completes on the rising edge where
    // psel, penable and pready are all 1. prdata/pslverr are meaningful only
    // while pready=1. Dropping psel during the access phase abandons the transfer.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W-4:0] DEPTH_WORDS = (ADDR_W-3)'(DEPTH);
    localparam logic [3:0]        WAIT_LOAD   = 4'(WAIT_CYCLES);

    state_t             state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_write;
    logic               lat_err;
    logic [DATA_W-1:0]  lat_wdata;
    logic [DATA_W-1:0]  regs [DEPTH];

    logic               setup;
    logic               violation;
    logic [IDX_W-1:0]   setup_idx;
    logic               setup_err;
    logic [DATA_W-1:0]  setup_rdata;
    logic [DATA_W-1:0]  lat_rdata;
    logic               unused_sel;

    // The top address bit selects this slave on the fabric side only.
    assign unused_sel  = paddr[ADDR_W-1];

    assign setup       = psel && !penable;
    assign violation   = psel && penable;
    assign setup_idx   = paddr[IDX_W+1:2];
    assign setup_err   = (paddr[1:0] != 2'b00) || (paddr[ADDR_W-2:2] >= DEPTH_WORDS);
    assign setup_rdata = (pwrite || setup_err) ? '0 : regs[setup_idx];
    assign lat_rdata   = (lat_write || lat_err) ? '0 : regs[lat_idx];
    assign fsm_state   = state;

    always_ff @(posedge pclk) begin
        if (!preset) begin
            state     <= IDLE;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                // DONE is a one-cycle marker; it accepts a new setup like IDLE.
                IDLE, DONE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    state   <= IDLE;
                    if (setup) begin
                        lat_idx   <= setup_idx;
                        lat_write <= pwrite;
                        lat_err   <= setup_err;
                        lat_wdata <= pwdata;
                        cnt       <= WAIT_LOAD;
                        state     <= ACCESS;
                        if (WAIT_CYCLES == 0) begin
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            prdata  <= setup_rdata;
                        end
                    end else if (violation) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        prdata  <= '0;
                        state   <= DONE;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                        state   <= IDLE;
                    end else if (penable) begin
                        if (pready) begin
                            if (lat_write && !lat_err) begin
                                regs[lat_idx] <= lat_wdata;
                            end
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            prdata  <= '0;
                            state   <= DONE;
                        end else if (cnt > 4'd1) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            pready  <= 1'b1;
                            pslverr <= lat_err;
                            prdata  <= lat_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 2 and 3 wait states) on a
// shared bus with individual psel lines, checked against a register model.
module tb_apb_slave_regfile;

    logic        pclk;
    logic        preset;
    logic        penable;
    logic        pwrite;
    logic [32:0] paddr;
    logic [31:0] pwdata;
    logic        psel_a    [3];
    logic [31:0] prdata_a  [3];
    logic        pready_a  [3];
    logic        pslverr_a [3];
    logic [1:0]  state_a   [3];

    logic [32:0] exp_q [$];
    logic [31:0] mdl [3][16];
    int          n_chk;
    int          n_err;

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_W(33), .DATA_W(32)) u_w0 (
        .pclk(pclk), .preset(preset), .psel(psel_a[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[0]),
        .pready(pready_a[0]), .pslverr(pslverr_a[0]), .fsm_state(state_a[0])
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(2), .ADDR_W(33), .DATA_W(32)) u_w2 (
        .pclk(pclk), .preset(preset), .psel(psel_a[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[1]),
        .pready(pready_a[1]), .pslverr(pslverr_a[1]), .fsm_state(state_a[1])
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(3), .ADDR_W(33), .DATA_W(32)) u_w3 (
        .pclk(pclk), .preset(preset), .psel(psel_a[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[2]),
        .pready(pready_a[2]), .pslverr(pslverr_a[2]), .fsm_state(state_a[2])
    );

    function automatic int wait_of(input int id);
        case (id)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        foreach (mdl[i, j]) mdl[i][j] = 32'h0;
    endtask

    // driver tasks
    task automatic bus_idle();
        @(negedge pclk);
        foreach (psel_a[i]) psel_a[i] = 1'b0;
        penable = 1'b0;
    endtask

    // Leaves the bus in the access phase with pready seen high, so the next
    // call may issue its setup phase back-to-back.
    task automatic xfer(input int id, input bit wr, input logic [32:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata,
                        output logic err_o);
        logic        err;
        logic [32:0] exp;
        logic [32:0] got;
        int          waits;
        err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd16);
        exp = {err, (wr || err) ? 32'h0 : mdl[id][addr[5:2]]};
        exp_q.push_back(exp);
        @(negedge pclk);
        psel_a[id] = 1'b1;
        penable    = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = data;
        @(negedge pclk);
        penable = 1'b1;
        paddr   = 33'($urandom);
        pwdata  = $urandom;
        waits   = 0;
        while (!pready_a[id] && waits < 40) begin
            @(negedge pclk);
            waits++;
        end
        got = {pslverr_a[id], prdata_a[id]};
        if (!pready_a[id]) begin
            check("pready_timeout", 64'(pready_a[id]), 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check("wait_states", 64'(waits), 64'(wait_of(id)));
            check("response", 64'(got), 64'(exp_q.pop_front()));
            if (wr && !err) mdl[id][addr[5:2]] = data;
        end
        rdata = prdata_a[id];
        err_o = pslverr_a[id];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [32:0] a;
        int          word;
        n_chk   = 0;
        n_err   = 0;
        preset  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        foreach (psel_a[i]) psel_a[i] = 1'b0;
        clear_model();
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            check("rst_pready", 64'(pready_a[i]), 64'd0);
            check("rst_pslverr", 64'(pslverr_a[i]), 64'd0);
            check("rst_prdata", 64'(prdata_a[i]), 64'd0);
            check("rst_state", 64'(state_a[i]), 64'd0);
        end
        preset = 1'b1;

        // zero wait states: write then read back
        xfer(0, 1'b1, 33'h8, 32'hDEADBEEF, rd, er);
        check("w0_write_err", 64'(er), 64'd0);
        bus_idle();
        xfer(0, 1'b0, 33'h8, 32'h0, rd, er);
        check("w0_read_data", 64'(rd), 64'hDEADBEEF);
        bus_idle();

        // three wait states
        xfer(2, 1'b1, 33'h3C, 32'h12345678, rd, er);
        bus_idle();
        xfer(2, 1'b0, 33'h3C, 32'h0, rd, er);
        check("w3_read_data", 64'(rd), 64'h12345678);
        bus_idle();

        // error accesses and the ignored slave-select bit
        xfer(0, 1'b0, 33'h40, 32'h0, rd, er);
        check("oor_err", 64'(er), 64'd1);
        check("oor_data", 64'(rd), 64'd0);
        bus_idle();
        xfer(0, 1'b1, 33'h5, 32'hFFFFFFFF, rd, er);
        check("misaligned_err", 64'(er), 64'd1);
        bus_idle();
        xfer(0, 1'b0, 33'h4, 32'h0, rd, er);
        check("misaligned_nowrite", 64'(rd), 64'd0);
        bus_idle();
        xfer(0, 1'b0, 33'h1_0000_0008, 32'h0, rd, er);
        check("selbit_data", 64'(rd), 64'hDEADBEEF);
        check("selbit_err", 64'(er), 64'd0);
        bus_idle();

        // abort a two-wait-state write in its second access cycle
        xfer(1, 1'b1, 33'h4, 32'h0BADF00D, rd, er);
        bus_idle();
        @(negedge pclk);
        psel_a[1] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 33'h4;
        pwdata    = 32'hAAAA5555;
        @(negedge pclk);
        penable = 1'b1;
        check("abort_acc1_pready", 64'(pready_a[1]), 64'd0);
        @(negedge pclk);
        check("abort_acc2_pready", 64'(pready_a[1]), 64'd0);
        psel_a[1] = 1'b0;
        penable   = 1'b0;
        @(negedge pclk);
        check("abort_after_pready", 64'(pready_a[1]), 64'd0);
        check("abort_state", 64'(state_a[1]), 64'd0);
        xfer(1, 1'b0, 33'h4, 32'h0, rd, er);
        check("abort_old_value", 64'(rd), 64'h0BADF00D);
        bus_idle();

        // back-to-back write then read
        xfer(0, 1'b1, 33'h0, 32'h1, rd, er);
        xfer(0, 1'b0, 33'h0, 32'h0, rd, er);
        check("b2b_read", 64'(rd), 64'h1);
        bus_idle();

        // random traffic, mixing idle gaps and back-to-back transfers
        for (int n = 0; n < 24; n++) begin
            word = $urandom_range(0, 19);
            a = {1'($urandom_range(0, 1)), 30'(word), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            xfer(1, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
            if ($urandom_range(0, 1) == 1) bus_idle();
        end
        bus_idle();

        // reset during a read's wait state
        @(negedge pclk);
        psel_a[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 33'h3C;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("rst_mid_wait", 64'(pready_a[2]), 64'd0);
        preset = 1'b0;
        @(negedge pclk);
        check("rst_mid_pready", 64'(pready_a[2]), 64'd0);
        check("rst_mid_state", 64'(state_a[2]), 64'd0);
        psel_a[2] = 1'b0;
        penable   = 1'b0;
        preset    = 1'b1;
        clear_model();
        for (int i = 0; i < 16; i++) begin
            xfer(2, 1'b0, 33'(i * 4), 32'h0, rd, er);
            check("post_rst_zero", 64'(rd), 64'd0);
            bus_idle();
        end

        // protocol violation from IDLE
        @(negedge pclk);
        psel_a[0] = 1'b1;
        penable   = 1'b1;
        pwrite    = 1'b1;
        paddr     = 33'h8;
        pwdata    = 32'hFFFFFFFF;
        @(negedge pclk);
        check("viol_pready", 64'(pready_a[0]), 64'd1);
        check("viol_pslverr", 64'(pslverr_a[0]), 64'd1);
        check("viol_prdata", 64'(prdata_a[0]), 64'd0);
        psel_a[0] = 1'b0;
        penable   = 1'b0;
        @(negedge pclk);
        check("viol_release", 64'(pready_a[0]), 64'd0);
        xfer(0, 1'b0, 33'h8, 32'h0, rd, er);
        check("viol_nowrite", 64'(rd), 64'd0);
        bus_idle();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
